alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Command sequencer that sits directly upstream of the 8-bit ALU. It accepts operation commands over a valid/ready handshake and registers the operands and select onto the ALU inputs. One cycle later it captures the ALU result and flags into an accumulator and a result register, then presents them downstream over a second valid/ready handshake. The accumulator can be used as operand a, so ALU operations can be chained without external storage.

Parameters:
WIDTH, 8, data width of operands, accumulator and result; matches the ALU a/b/out width.
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  input  1  single system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  block can accept a command.
cmd_op  input  3  ALU select code, forwarded unchanged to alu_sel.
cmd_src  input  1  operand a source: 0 selects cmd_a, 1 selects the accumulator.
cmd_a  input  WIDTH  operand a, used when cmd_src=0.
cmd_b  input  WIDTH  operand b.
acc_clr  input  1  synchronous accumulator clear.
alu_a  output  WIDTH  registered operand a to the ALU.
alu_b  output  WIDTH  registered operand b to the ALU.
alu_sel  output  3  registered select to the ALU.
alu_out  input  WIDTH  ALU result (combinational from alu_a/alu_b/alu_sel).
alu_carry  input  1  ALU carry flag.
alu_zero  input  1  ALU zero flag.
res_valid  output  1  result present.
res_ready  input  1  downstream accepts the result.
res_data  output  WIDTH  captured ALU result.
res_carry  output  1  captured carry flag.
res_zero  output  1  captured zero flag.
acc  output  WIDTH  accumulator value.
op_count  output  CNT_W  number of results accepted downstream.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State is IDLE.
  - alu_a, alu_b, alu_sel, res_data, res_carry, res_zero, acc, op_count and res_valid are all 0.
  - cmd_ready = (state==IDLE), so it reads 1 while reset is held.
- State IDLE:
  - cmd_ready=1, res_valid=0.
  - On a clock edge with cmd_valid=1 (accept): alu_a <= cmd_src ? acc : cmd_a; alu_b <= cmd_b; alu_sel <= cmd_op; next state EXEC.
  - With cmd_valid=0, the block stays in IDLE and the alu_* registers hold.
- State EXEC (exactly 1 cycle):
  - cmd_ready=0, res_valid=0. The ALU settles combinationally.
  - At the end-of-cycle edge: res_data <= alu_out, res_carry <= alu_carry, res_zero <= alu_zero, acc <= alu_out; next state DONE.
- State DONE:
  - res_valid=1, cmd_ready=0. res_data, res_carry and res_zero are held stable while res_ready=0.
  - On an edge with res_ready=1: op_count increments (wraps from 2^CNT_W-1 to 0); next state IDLE.
- Latency and throughput:
  - Accept edge to res_valid high is 2 edges.
  - Minimum spacing between accepted commands is 3 cycles; there is no back-to-back acceptance.
- alu_a, alu_b and alu_sel change only on an accept edge. They hold their values through EXEC, DONE and IDLE.
- acc_clr:
  - Clears acc to 0 on any edge, in any state.
  - If asserted on the EXEC capture edge, the clear wins: acc=0, but res_data still captures alu_out.
  - If asserted on an accept edge with cmd_src=1, alu_a takes the pre-clear acc value.
- The accumulator is updated only by the capture or by acc_clr; the result handshake does not affect it.
- Reset asserted mid-operation (EXEC or DONE) aborts the operation. The pending result is discarded, op_count does not increment, and all registers return to their reset values.
- The block has no knowledge of opcode semantics; cmd_op is passed through to alu_sel untouched.

Test Plan:
- AND: cmd_op=000, cmd_src=0, a=0xCC, b=0xAA.
  - Expect alu_a=0xCC, alu_b=0xAA, alu_sel=000 during EXEC.
  - Two edges after accept: res_valid=1, res_data=0x88, res_zero=0, acc=0x88.
- ADD overflow: op=010, a=0xFF, b=0x01.
  - Expect res_data=0x00, res_carry=1, res_zero=1; op_count=1 after res_ready=1 for one edge.
- Accumulator chaining: ADD a=0x05, b=0x00 (acc=0x05), then ADD with cmd_src=1, b=0x03.
  - Expect alu_a=0x05 in the second EXEC, res_data=0x08, acc=0x08.
- Backpressure: NOT (101) of a=0xAA with res_ready held 0 for 5 cycles.
  - Expect res_valid=1 and res_data=0x55 stable throughout, cmd_ready=0, a cmd_valid pulse ignored.
  - After res_ready=1: IDLE, cmd_ready=1.
- Clear collision: SHL (111) of a=0x01 with acc_clr=1 on the EXEC edge.
  - Expect res_data=0x02, acc=0x00.
- Reset in DONE: drop rst_n asynchronously with res_valid=1.
  - Expect res_valid=0, res_data=0, acc=0, op_count unchanged from its reset value 0, and cmd_ready=1 immediately without a clock edge.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Command sequencer in front of the 8-bit ALU: registers operands/select, captures
// the result one cycle later, and hands it downstream with an accumulator for chaining.
module alu_issue_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic             cmd_src,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             acc_clr,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    input  logic             alu_zero,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_carry,
    output logic             res_zero,
    output logic [WIDTH-1:0] acc,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] alu_a_reg, alu_b_reg, res_data_reg, acc_reg;
    logic [2:0]       alu_sel_reg;
    logic             res_carry_reg, res_zero_reg;
    logic [CNT_W-1:0] op_count_reg;

    logic accept, capture, release_res;

    assign accept      = (state_reg == IDLE) && cmd_valid;
    assign capture     = (state_reg == EXEC);
    assign release_res = (state_reg == DONE) && res_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        cmd_ready  = 1'b0;
        res_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_next = EXEC;
            end
            EXEC: state_next = DONE;
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // alu_a samples the accumulator before any same-edge clear takes effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_reg     <= '0;
            alu_b_reg     <= '0;
            alu_sel_reg   <= '0;
            res_data_reg  <= '0;
            res_carry_reg <= 1'b0;
            res_zero_reg  <= 1'b0;
            acc_reg       <= '0;
            op_count_reg  <= '0;
        end else begin
            if (accept) begin
                alu_a_reg   <= cmd_src ? acc_reg : cmd_a;
                alu_b_reg   <= cmd_b;
                alu_sel_reg <= cmd_op;
            end
            if (capture) begin
                res_data_reg  <= alu_out;
                res_carry_reg <= alu_carry;
                res_zero_reg  <= alu_zero;
            end
            if (acc_clr)      acc_reg <= '0;
            else if (capture) acc_reg <= alu_out;
            if (release_res)
                op_count_reg <= op_count_reg + CNT_W'(1);
        end
    end

    assign alu_a     = alu_a_reg;
    assign alu_b     = alu_b_reg;
    assign alu_sel   = alu_sel_reg;
    assign res_data  = res_data_reg;
    assign res_carry = res_carry_reg;
    assign res_zero  = res_zero_reg;
    assign acc       = acc_reg;
    assign op_count  = op_count_reg;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: a bench-side 8-bit ALU closes the loop and a
// transaction-level model tracks accumulator, operands and the result counter.
module tb_alu_issue_ctrl;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_src, acc_clr;
    logic [2:0]    cmd_op, alu_sel;
    logic [W-1:0]  cmd_a, cmd_b, alu_a, alu_b, alu_out, res_data, acc;
    logic          alu_carry, alu_zero, res_valid, res_ready, res_carry, res_zero;
    logic [CW-1:0] op_count;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_acc;
    int           m_cnt;

    alu_issue_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_src(cmd_src),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .acc_clr(acc_clr),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_carry(res_carry), .res_zero(res_zero),
        .acc(acc), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // {carry, result} of the reference ALU
    function automatic logic [8:0] alu_f(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] r;
        case (sel)
            3'd0: r = {1'b0, a & b};
            3'd1: r = {1'b0, a | b};
            3'd2: r = {1'b0, a} + {1'b0, b};
            3'd3: r = {1'b0, a} - {1'b0, b};
            3'd4: r = {1'b0, a ^ b};
            3'd5: r = {1'b0, ~a};
            3'd6: r = {a[0], 1'b0, a[7:1]};
            default: r = {a[7], a[6:0], 1'b0};
        endcase
        return r;
    endfunction

    logic [8:0] alu_r;
    always_comb begin
        alu_r     = alu_f(alu_sel, alu_a, alu_b);
        alu_out   = alu_r[7:0];
        alu_carry = alu_r[8];
        alu_zero  = (alu_r[7:0] == 8'h00);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_res_data"},  32'(res_data),  32'd0);
        check({tag, "_res_flags"}, 32'({res_carry, res_zero}), 32'd0);
        check({tag, "_acc"},       32'(acc),       32'd0);
        check({tag, "_op_count"},  32'(op_count),  32'd0);
        check({tag, "_alu_regs"},  32'({alu_a, alu_b, alu_sel}), 32'd0);
    endtask

    task automatic idle_cycles(input int n, input logic clr);
        logic [18:0] held;
        held = {alu_a, alu_b, alu_sel};
        for (int i = 0; i < n; i++) begin
            acc_clr = clr && (i == 0);
            if (acc_clr) m_acc = '0;
            step();
            acc_clr = 1'b0;
            check("idle_hold", 32'({alu_a, alu_b, alu_sel}), 32'(held));
            check("idle_acc", 32'(acc), 32'(m_acc));
            check("idle_ready", 32'({cmd_ready, res_valid}), 32'b10);
        end
    endtask

    task automatic do_op(input logic [2:0] op, input logic src, input logic [7:0] a, input logic [7:0] b,
                         input logic clr_acc, input logic clr_exec, input int stall, input logic abort);
        logic [7:0] ea;
        logic [8:0] r;
        check("pre_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_src = src; cmd_a = a; cmd_b = b; acc_clr = clr_acc;
        ea = src ? m_acc : a;
        if (clr_acc) m_acc = '0;
        step();
        cmd_valid = 1'b0; acc_clr = clr_exec;
        cmd_a = W'($urandom); cmd_b = W'($urandom); cmd_op = 3'($urandom); cmd_src = 1'($urandom);
        check("exec_alu_a", 32'(alu_a), 32'(ea));
        check("exec_alu_b", 32'(alu_b), 32'(b));
        check("exec_alu_sel", 32'(alu_sel), 32'(op));
        check("exec_hs", 32'({cmd_ready, res_valid}), 32'b00);
        check("exec_acc", 32'(acc), 32'(m_acc));
        r = alu_f(op, ea, b);
        m_acc = clr_exec ? 8'h00 : r[7:0];
        step();
        acc_clr = 1'b0;
        check("done_hs", 32'({cmd_ready, res_valid}), 32'b01);
        check("done_data", 32'(res_data), 32'(r[7:0]));
        check("done_flags", 32'({res_carry, res_zero}), 32'({r[8], r[7:0] == 8'h00}));
        check("done_acc", 32'(acc), 32'(m_acc));
        $display("op=%0d src=%0d a=%02h b=%02h -> res=%02h c=%0d z=%0d acc=%02h",
                 op, src, ea, b, res_data, res_carry, res_zero, acc);
        if (abort) begin
            #2 rst_n = 1'b0;
            #1;
            m_acc = '0;
            m_cnt = 0;
            check_reset_state("abort");
            step();
            #2 rst_n = 1'b1;
            step();
            check_reset_state("post_abort");
            return;
        end
        for (int i = 0; i < stall; i++) begin
            res_ready = 1'b0;
            cmd_valid = (i == 1);
            cmd_src   = 1'b0;
            step();
            cmd_valid = 1'b0;
            check("stall_hs", 32'({cmd_ready, res_valid}), 32'b01);
            check("stall_data", 32'({res_data, res_carry, res_zero}), 32'({r[7:0], r[8], r[7:0] == 8'h00}));
            check("stall_alu_a", 32'(alu_a), 32'(ea));
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        m_cnt = (m_cnt + 1) % (1 << CW);
        check("rel_count", 32'(op_count), 32'(m_cnt));
        check("rel_hs", 32'({cmd_ready, res_valid}), 32'b10);
        check("rel_acc", 32'(acc), 32'(m_acc));
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_src = 1'b0;
        cmd_a = '0; cmd_b = '0; acc_clr = 1'b0; res_ready = 1'b0;
        m_acc = '0; m_cnt = 0;
        #1;
        check_reset_state("reset");
        #11 rst_n = 1'b1;
        step();
        check_reset_state("after_reset");

        do_op(3'b000, 1'b0, 8'hCC, 8'hAA, 1'b0, 1'b0, 0, 1'b0);   // AND
        do_op(3'b010, 1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, 0, 1'b0);   // ADD overflow
        do_op(3'b010, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0, 1, 1'b0);   // chain seed
        do_op(3'b010, 1'b1, 8'h77, 8'h03, 1'b0, 1'b0, 0, 1'b0);   // chain from acc
        idle_cycles(3, 1'b0);
        do_op(3'b101, 1'b0, 8'hAA, 8'h00, 1'b0, 1'b0, 5, 1'b0);   // NOT with backpressure
        do_op(3'b111, 1'b0, 8'h01, 8'h00, 1'b0, 1'b1, 0, 1'b0);   // SHL with clear on capture
        do_op(3'b001, 1'b0, 8'h30, 8'h03, 1'b0, 1'b0, 0, 1'b0);
        do_op(3'b100, 1'b1, 8'h00, 8'hFF, 1'b1, 1'b0, 0, 1'b0);   // clear on accept, src=acc
        idle_cycles(2, 1'b1);

        for (int k = 0; k < 24; k++) begin
            do_op(3'($urandom), 1'($urandom), W'($urandom), W'($urandom),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                  int'($urandom_range(0, 3)), 1'b0);
            if ($urandom_range(0, 3) == 0)
                idle_cycles(int'($urandom_range(1, 3)), 1'($urandom));
        end

        do_op(3'b011, 1'b0, 8'h10, 8'h20, 1'b0, 1'b0, 0, 1'b1);   // reset while in DONE
        do_op(3'b000, 1'b0, 8'hF0, 8'h3C, 1'b0, 1'b0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
